// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the future receiver.
// Contents: FSM state encodings, parity mode codes and a parity helper.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP,
        S_BREAK  = ST_BREAK
    } uart_state_t;

    // Parity mode codes; 2'b11 is treated as no parity.
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Widest supported payload; narrower payloads are zero-extended,
    // which leaves the XOR unchanged.
    localparam int PAR_DATA_W = 9;

    function automatic logic calc_parity(input logic [PAR_DATA_W-1:0] data,
                                         input logic [1:0]            mode);
        logic par;
        case (mode)
            PAR_EVEN: par = ^data;
            PAR_ODD:  par = ~^data;
            default:  par = 1'b0;
        endcase
        return par;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-interval timer shared by the UART transmitter and receiver.
// Ports:
//   clk     - system clock
//   rst     - asynchronous active-low reset
//   clr     - synchronous restart of the interval (state change)
//   bit_end - high in the last cycle of each CLKS_PER_BIT-cycle interval
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Wraps at terminal count so multi-interval states (DATA, two-bit STOP)
    // keep a steady bit rate without needing a state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr || bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bit_end = (r_cnt == CNT_TC);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: 5..9 data bits, optional even/odd parity,
// 1 or 2 stop bits, valid/ready input handshake and line-break request.
// Ports:
//   clk, rst              - system clock, asynchronous active-low reset
//   tx_valid / tx_ready   - frame handshake, accept when both high
//   tx_data               - payload, sent LSB first
//   cfg_parity, cfg_stop2 - frame format, captured at accept
//   tx_break              - hold line low while idle
//   tx                    - registered serial output, idles high
//   tx_busy, tx_done      - frame in progress / end-of-frame pulse
//   tx_state              - current FSM state for status readback
//
// state  | meaning
// IDLE   | line high, ready for a frame or a break request
// START  | start bit (low) for one interval
// DATA   | DATA_W payload bits, LSB first
// PARITY | optional parity bit
// STOP   | one or two stop intervals (high), then tx_done
// BREAK  | line held low until tx_break drops
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [1:0]        cfg_parity,
    input  logic              cfg_stop2,
    input  logic              tx_break,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done,
    output logic [2:0]        tx_state
);

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    uart_state_t             r_state;
    uart_state_t             w_state_next;
    logic [DATA_W-1:0]       r_shift;
    logic [BIT_W-1:0]        r_bit_cnt;
    logic                    r_stop_cnt;
    logic [1:0]              r_par_mode;
    logic                    r_stop2;
    logic                    r_par_bit;
    logic                    r_tx;
    logic                    r_done;
    logic                    r_run;
    logic                    w_bit_end;
    logic                    w_clr;
    logic                    w_accept;
    logic                    w_done;
    logic                    w_tx;
    logic [PAR_DATA_W-1:0]   w_data_ext;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_clr),
        .bit_end(w_bit_end)
    );

    always_comb begin
        w_data_ext = '0;
        w_data_ext[DATA_W-1:0] = tx_data;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        w_tx         = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_tx = 1'b1;
                if (tx_break) begin
                    w_state_next = S_BREAK;
                end else if (tx_valid && r_run) begin
                    w_accept     = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_tx = 1'b0;
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_tx = r_shift[0];
                if (w_bit_end && (r_bit_cnt == LAST_BIT)) begin
                    if ((r_par_mode == PAR_EVEN) || (r_par_mode == PAR_ODD)) begin
                        w_state_next = S_PARITY;
                    end else begin
                        w_state_next = S_STOP;
                    end
                end
            end
            S_PARITY: begin
                w_tx = r_par_bit;
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                w_tx = 1'b1;
                if (w_bit_end && (!r_stop2 || r_stop_cnt)) begin
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_BREAK: begin
                w_tx = 1'b0;
                if (!tx_break) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // The baud interval restarts on any state change so each state begins
    // on a fresh bit boundary.
    assign w_clr = (w_state_next != r_state);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Parity is computed from the payload at accept because the shift
    // register is consumed while the data bits go out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_par_mode <= PAR_NONE;
            r_stop2    <= 1'b0;
            r_par_bit  <= 1'b0;
        end else if (w_accept) begin
            r_shift    <= tx_data;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_par_mode <= cfg_parity;
            r_stop2    <= cfg_stop2;
            r_par_bit  <= calc_parity(w_data_ext, cfg_parity);
        end else if (w_bit_end) begin
            if (r_state == S_DATA) begin
                r_shift   <= {1'b0, r_shift[DATA_W-1:1]};
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
            if (r_state == S_STOP) begin
                r_stop_cnt <= 1'b1;
            end
        end
    end

    // tx follows the state one cycle late, so the line changes on the edge
    // after the state does; r_run keeps tx_ready low until the first clock
    // after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx   <= 1'b1;
            r_done <= 1'b0;
            r_run  <= 1'b0;
        end else begin
            r_tx   <= w_tx;
            r_done <= w_done;
            r_run  <= 1'b1;
        end
    end

    assign tx       = r_tx;
    assign tx_done  = r_done;
    assign tx_ready = r_run && (r_state == S_IDLE);
    assign tx_busy  = (r_state == S_START) || (r_state == S_DATA) ||
                      (r_state == S_PARITY) || (r_state == S_STOP);
    assign tx_state = r_state;

endmodule

// File: tb/tb_uart_tx_param.sv
module tb_uart_tx_param;

    localparam int CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       valid_a, break_a, stop2_a, ready_a, tx_a, busy_a, done_a;
    logic [7:0] data_a;
    logic [1:0] par_a;
    logic [2:0] state_a;
    logic       valid_b, break_b, stop2_b, ready_b, tx_b, busy_b, done_b;
    logic [4:0] data_b;
    logic [1:0] par_b;
    logic [2:0] state_b;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_bits[$];

    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(CPB)) dut_a (
        .clk(clk), .rst(rst), .tx_valid(valid_a), .tx_ready(ready_a),
        .tx_data(data_a), .cfg_parity(par_a), .cfg_stop2(stop2_a),
        .tx_break(break_a), .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a),
        .tx_state(state_a)
    );

    uart_tx_param #(.DATA_W(5), .CLKS_PER_BIT(CPB)) dut_b (
        .clk(clk), .rst(rst), .tx_valid(valid_b), .tx_ready(ready_b),
        .tx_data(data_b), .cfg_parity(par_b), .cfg_stop2(stop2_b),
        .tx_break(break_b), .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b),
        .tx_state(state_b)
    );

    task automatic drive(input int dut, input logic v, input logic [8:0] d,
                         input logic [1:0] p, input logic s2);
        if (dut == 0) begin
            valid_a = v; data_a = d[7:0]; par_a = p; stop2_a = s2;
        end else begin
            valid_b = v; data_b = d[4:0]; par_b = p; stop2_b = s2;
        end
    endtask

    task automatic sample(input int dut, output logic t, output logic b,
                          output logic r, output logic dn, output logic [2:0] st);
        if (dut == 0) begin
            t = tx_a; b = busy_a; r = ready_a; dn = done_a; st = state_a;
        end else begin
            t = tx_b; b = busy_b; r = ready_b; dn = done_b; st = state_b;
        end
    endtask

    // Reference line image: start, payload LSB first, optional parity, stops.
    task automatic build_exp(input int dw, input logic [8:0] d,
                             input logic [1:0] p, input logic s2);
        int ones;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < dw; i++) begin
            exp_bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (p == 2'b01) exp_bits.push_back((ones % 2) == 1);
        if (p == 2'b10) exp_bits.push_back((ones % 2) == 0);
        exp_bits.push_back(1'b1);
        if (s2) exp_bits.push_back(1'b1);
    endtask

    // Starts at a negedge with the DUT idle; ends at the negedge where
    // tx_done should be high.
    task automatic run_frame(input int dut, input logic [8:0] d, input logic [1:0] p,
                             input logic s2, input int hold, input int disturb);
        int dw, f, bad_tx, bad_busy, bad_rdy, bad_done, first_k;
        logic t, b, r, dn, exp_t;
        logic [2:0] st;
        dw = (dut == 0) ? 8 : 5;
        build_exp(dw, d, p, s2);
        f = exp_bits.size() * CPB;
        bad_tx = 0; bad_busy = 0; bad_rdy = 0; bad_done = 0; first_k = -1;
        drive(dut, 1'b1, d, p, s2);
        @(posedge clk);
        @(negedge clk);
        if (hold == 0) drive(dut, 1'b0, d, p, s2);
        sample(dut, t, b, r, dn, st);
        n_tests++;
        if (b !== 1'b1 || t !== 1'b1 || dn !== 1'b0 || r !== 1'b0) begin
            n_fail++;
            $display("FAIL accept d=%h busy=%b tx=%b done=%b ready=%b, need 1 1 0 0", d, b, t, dn, r);
        end
        for (int k = 1; k <= f; k++) begin
            @(posedge clk);
            @(negedge clk);
            sample(dut, t, b, r, dn, st);
            exp_t = exp_bits[(k - 1) / CPB];
            if (t !== exp_t) begin
                bad_tx++;
                if (first_k < 0) first_k = k;
            end
            if (b !== (k < f)) bad_busy++;
            if (r !== (k == f)) bad_rdy++;
            if (k == f && st !== 3'd0) bad_rdy++;
            if (dn !== (k == f)) bad_done++;
            if (disturb != 0 && k == 10) drive(dut, 1'b1, ~d, ~p, ~s2);
            if (disturb != 0 && k == 11) drive(dut, 1'b0, ~d, ~p, ~s2);
        end
        n_tests++;
        if (bad_tx !== 0) begin
            n_fail++;
            $display("FAIL frame_tx d=%h par=%b stop2=%b bad_cycles=%0d first_k=%0d, need 0", d, p, s2, bad_tx, first_k);
        end
        n_tests++;
        if (bad_busy !== 0) begin
            n_fail++;
            $display("FAIL frame_busy d=%h bad_cycles=%0d, need 0 (busy for %0d cycles)", d, bad_busy, f);
        end
        n_tests++;
        if (bad_rdy !== 0) begin
            n_fail++;
            $display("FAIL frame_ready d=%h bad_cycles=%0d, need 0", d, bad_rdy);
        end
        n_tests++;
        if (bad_done !== 0) begin
            n_fail++;
            $display("FAIL frame_done d=%h bad_cycles=%0d, need pulse only at cycle %0d", d, bad_done, f);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(0, 1'b0, 9'h0, 2'b00, 1'b0);
        drive(1, 1'b0, 9'h0, 2'b00, 1'b0);
        break_a = 1'b0; break_b = 1'b0;
        #12;
        n_tests++;
        if ({tx_a, ready_a, busy_a, done_a, state_a} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_a tx/rdy/busy/done/state=%b, need 1000000", {tx_a, ready_a, busy_a, done_a, state_a});
        end
        n_tests++;
        if ({tx_b, ready_b, busy_b, done_b, state_b} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_b tx/rdy/busy/done/state=%b, need 1000000", {tx_b, ready_b, busy_b, done_b, state_b});
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset got %b%b, need 11", ready_a, ready_b);
        end
    endtask

    task automatic test_basic();
        run_frame(0, 9'h0A5, 2'b00, 1'b0, 0, 0);
    endtask

    task automatic test_parity();
        run_frame(0, 9'h0A5, 2'b01, 1'b0, 0, 1);
        run_frame(0, 9'h0A5, 2'b10, 1'b0, 0, 1);
    endtask

    task automatic test_stop2();
        run_frame(0, 9'h03C, 2'b00, 1'b1, 0, 0);
        run_frame(1, 9'h015, 2'b00, 1'b0, 0, 0);
        run_frame(1, 9'h00B, 2'b10, 1'b1, 0, 1);
    endtask

    task automatic test_back_to_back();
        run_frame(0, 9'h055, 2'b00, 1'b0, 1, 0);
        run_frame(0, 9'h0AA, 2'b00, 1'b0, 0, 0);
    endtask

    task automatic test_reset_mid_frame();
        drive(0, 1'b1, 9'h000, 2'b00, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 9'h000, 2'b00, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_tests++;
        if (tx_a !== 1'b0 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset tx=%b busy=%b, need 0 1", tx_a, busy_a);
        end
        #1 rst = 1'b0;
        #1;
        n_tests++;
        if ({tx_a, busy_a, done_a, ready_a, state_a} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL async_reset tx/busy/done/rdy/state=%b, need 1000000", {tx_a, busy_a, done_a, ready_a, state_a});
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (ready_a !== 1'b1 || tx_a !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset ready=%b tx=%b, need 1 1", ready_a, tx_a);
        end
        run_frame(0, 9'h081, 2'b00, 1'b0, 0, 0);
    endtask

    task automatic test_break();
        int bad;
        logic [8:0] d;
        bad = 0;
        d = 9'($urandom_range(0, 255));
        drive(0, 1'b1, d, 2'b00, 1'b0);
        break_a = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (tx_a !== (c < 2)) bad++;
            if (busy_a !== 1'b0) bad++;
            if (ready_a !== (c == 11)) bad++;
            if (state_a !== ((c <= 10) ? 3'd5 : 3'd0)) bad++;
            if (c == 10) break_a = 1'b0;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL break_window bad_checks=%0d, need 0", bad);
        end
        run_frame(0, d, 2'b00, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        logic [8:0] d;
        logic [1:0] p;
        logic       s2;
        for (int i = 0; i < 8; i++) begin
            d  = 9'($urandom_range(0, 511));
            p  = 2'($urandom_range(0, 3));
            s2 = 1'($urandom_range(0, 1));
            run_frame(i % 2, d, p, s2, 0, i % 3 == 0 ? 1 : 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_stop2();
        test_back_to_back();
        test_reset_mid_frame();
        test_break();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
